// File: rtl/riscv_opcodes_pkg.sv
// ============================================================================
// Module  : riscv_opcodes_pkg
// Purpose : Shared RISC-V register-index type and the x0 index constant.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_opcodes_pkg;

   // Architectural register index (x0..x31)
   typedef logic [4:0] rsd_t;

   // Hard-wired zero register index
   localparam rsd_t ZERO = 5'd0;

endpackage : riscv_opcodes_pkg

`default_nettype wire

// File: rtl/rf_operand_slot.sv
// ============================================================================
// Module  : rf_operand_slot
// Purpose : One operand lane: tracks a fetched source index through stalls,
//           resolves the operand from RF data, a captured fetch-edge bypass,
//           a same-cycle writeback forward, or a hold register.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_operand_slot
   import riscv_opcodes_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch,
   input  rsd_t        pd_src,
   input  logic [31:0] rf_q,
   input  logic        wb_we,
   input  rsd_t        wb_dst,
   input  logic [31:0] wb_d,
   output rsd_t        id_src,
   output logic [31:0] id_op
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRESH = 2'd1,
      HOLD  = 2'd2
   } slot_state_t;

   slot_state_t state;
   logic [31:0] hold_q;
   logic        byp_pend;
   logic [31:0] byp_data;
   logic [31:0] base_val;

   // Operand FSM, index register, fetch-edge bypass capture and hold register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         id_src   <= ZERO;
         hold_q   <= 32'd0;
         byp_pend <= 1'b0;
         byp_data <= 32'd0;
      end else if (fetch) begin
         state    <= FRESH;
         id_src   <= pd_src;
         // The RF read at this edge returns the pre-write value, so a
         // coincident write to the same index must be remembered here.
         byp_pend <= wb_we && (wb_dst == pd_src) && (pd_src != ZERO);
         byp_data <= wb_d;
      end else if (state == FRESH || state == HOLD) begin
         // Capture the resolved value so later writebacks during a stall
         // keep overwriting it (latest write wins).
         state  <= HOLD;
         hold_q <= id_op;
      end
   end

   // Operand resolution: x0 forcing, same-cycle forward, then state base value
   always_comb begin
      base_val = 32'd0;
      case (state)
         FRESH:   base_val = byp_pend ? byp_data : rf_q;
         HOLD:    base_val = hold_q;
         default: base_val = 32'd0;
      endcase

      id_op = base_val;
      if (id_src == ZERO) begin
         id_op = 32'd0;
      end else if (wb_we && (wb_dst == id_src)) begin
         id_op = wb_d;
      end
   end

endmodule : rf_operand_slot

`default_nettype wire

// File: rtl/rf_operand_fetch.sv
// ============================================================================
// Module  : rf_operand_fetch
// Purpose : Operand fetch between predecode and ID: drives the synchronous
//           register-file read addresses and resolves two source operands.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_operand_fetch
   import riscv_opcodes_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pd_stall_i,
   input  logic        id_stall_i,
   input  rsd_t        pd_src1_i,
   input  rsd_t        pd_src2_i,
   output rsd_t        rf_src1_o,
   output rsd_t        rf_src2_o,
   input  logic [31:0] rf_src1_q_i,
   input  logic [31:0] rf_src2_q_i,
   input  logic        wb_we_i,
   input  rsd_t        wb_dst_i,
   input  logic [31:0] wb_dst_d_i,
   output rsd_t        id_src1_o,
   output rsd_t        id_src2_o,
   output logic [31:0] id_op1_o,
   output logic [31:0] id_op2_o
);

   logic fetch;
   // ID-stage stall only signals an unconsumed operand; it has no effect on
   // resolution, so it is intentionally not connected to any logic.
   logic unused_id_stall;

   assign fetch           = ~pd_stall_i;
   assign unused_id_stall = id_stall_i;

   // While stalled, re-read the held index so the RF data stays coherent
   assign rf_src1_o = pd_stall_i ? id_src1_o : pd_src1_i;
   assign rf_src2_o = pd_stall_i ? id_src2_o : pd_src2_i;

   rf_operand_slot u_slot1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .fetch  (fetch),
      .pd_src (pd_src1_i),
      .rf_q   (rf_src1_q_i),
      .wb_we  (wb_we_i),
      .wb_dst (wb_dst_i),
      .wb_d   (wb_dst_d_i),
      .id_src (id_src1_o),
      .id_op  (id_op1_o)
   );

   rf_operand_slot u_slot2 (
      .clk    (clk),
      .rst_n  (rst_n),
      .fetch  (fetch),
      .pd_src (pd_src2_i),
      .rf_q   (rf_src2_q_i),
      .wb_we  (wb_we_i),
      .wb_dst (wb_dst_i),
      .wb_d   (wb_dst_d_i),
      .id_src (id_src2_o),
      .id_op  (id_op2_o)
   );

endmodule : rf_operand_fetch

`default_nettype wire

// File: tb/tb_rf_operand_fetch.sv
// ============================================================================
// Module  : tb_rf_operand_fetch
// Purpose : Directed self-checking bench for rf_operand_fetch with a
//           behavioural synchronous-read register file and an expectation
//           queue.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rf_operand_fetch;
   import riscv_opcodes_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        pd_stall_i;
   logic        id_stall_i;
   rsd_t        pd_src1_i;
   rsd_t        pd_src2_i;
   rsd_t        rf_src1_o;
   rsd_t        rf_src2_o;
   logic [31:0] rf_src1_q_i;
   logic [31:0] rf_src2_q_i;
   logic        wb_we_i;
   rsd_t        wb_dst_i;
   logic [31:0] wb_dst_d_i;
   rsd_t        id_src1_o;
   rsd_t        id_src2_o;
   logic [31:0] id_op1_o;
   logic [31:0] id_op2_o;

   typedef struct {
      string       tag;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  src1;
      logic [4:0]  src2;
      logic [4:0]  rf1;
      logic [4:0]  rf2;
   } exp_t;

   exp_t        sb[$];
   int          total;
   int          bad;
   logic [31:0] regs [32];

   rf_operand_fetch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pd_stall_i  (pd_stall_i),
      .id_stall_i  (id_stall_i),
      .pd_src1_i   (pd_src1_i),
      .pd_src2_i   (pd_src2_i),
      .rf_src1_o   (rf_src1_o),
      .rf_src2_o   (rf_src2_o),
      .rf_src1_q_i (rf_src1_q_i),
      .rf_src2_q_i (rf_src2_q_i),
      .wb_we_i     (wb_we_i),
      .wb_dst_i    (wb_dst_i),
      .wb_dst_d_i  (wb_dst_d_i),
      .id_src1_o   (id_src1_o),
      .id_src2_o   (id_src2_o),
      .id_op1_o    (id_op1_o),
      .id_op2_o    (id_op2_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural register file: synchronous read returns the pre-write value
   always @(posedge clk) begin
      rf_src1_q_i <= regs[rf_src1_o];
      rf_src2_q_i <= regs[rf_src2_o];
      if (wb_we_i && wb_dst_i != 5'd0) regs[wb_dst_i] <= wb_dst_d_i;
   end

   task automatic push_exp(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                           input logic [4:0] s1, input logic [4:0] s2,
                           input logic [4:0] r1, input logic [4:0] r2);
      exp_t e;
      e.tag = tag; e.op1 = e1; e.op2 = e2; e.src1 = s1; e.src2 = s2; e.rf1 = r1; e.rf2 = r2;
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL scoreboard_empty observed=0 expected>0");
         return;
      end
      e = sb.pop_front();
      total++;
      assert (id_op1_o === e.op1) else begin
         bad++; $error("FAIL %s_op1 observed=%h expected=%h", e.tag, id_op1_o, e.op1);
      end
      total++;
      assert (id_op2_o === e.op2) else begin
         bad++; $error("FAIL %s_op2 observed=%h expected=%h", e.tag, id_op2_o, e.op2);
      end
      total++;
      assert (id_src1_o === e.src1) else begin
         bad++; $error("FAIL %s_src1 observed=%0d expected=%0d", e.tag, id_src1_o, e.src1);
      end
      total++;
      assert (id_src2_o === e.src2) else begin
         bad++; $error("FAIL %s_src2 observed=%0d expected=%0d", e.tag, id_src2_o, e.src2);
      end
      total++;
      assert (rf_src1_o === e.rf1) else begin
         bad++; $error("FAIL %s_rf1 observed=%0d expected=%0d", e.tag, rf_src1_o, e.rf1);
      end
      total++;
      assert (rf_src2_o === e.rf2) else begin
         bad++; $error("FAIL %s_rf2 observed=%0d expected=%0d", e.tag, rf_src2_o, e.rf2);
      end
   endtask

   // One clock cycle: drive inputs just after the rising edge, record the
   // outputs expected during this cycle, compare at the falling edge.
   task automatic cyc(input string tag, input logic pst, input logic ist,
                      input logic [4:0] s1, input logic [4:0] s2,
                      input logic we, input logic [4:0] dst, input logic [31:0] d,
                      input logic [31:0] e1, input logic [31:0] e2,
                      input logic [4:0] es1, input logic [4:0] es2);
      pd_stall_i = pst;
      id_stall_i = ist;
      pd_src1_i  = s1;
      pd_src2_i  = s2;
      wb_we_i    = we;
      wb_dst_i   = dst;
      wb_dst_d_i = d;
      push_exp(tag, e1, e2, es1, es2, pst ? es1 : s1, pst ? es2 : s2);
      @(negedge clk);
      pop_check();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      regs[3]  = 32'h0000_0033;
      regs[5]  = 32'h1111_0000;
      regs[9]  = 32'h0000_0042;
      regs[12] = 32'h0000_0077;

      rst_n = 1'b0;
      pd_stall_i = 1'b1; id_stall_i = 1'b0;
      pd_src1_i = 5'd0; pd_src2_i = 5'd0;
      wb_we_i = 1'b0; wb_dst_i = 5'd0; wb_dst_d_i = 32'd0;
      @(posedge clk);
      #1;

      // Reset state
      cyc("reset", 1, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 0, 0);
      rst_n = 1'b1;
      cyc("idle", 1, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 0, 0);

      // Plain fetch of x5
      cyc("f5", 0, 0, 5, 0, 0, 0, 32'd0, 32'd0, 32'd0, 0, 0);
      cyc("f5_res", 1, 0, 0, 0, 0, 0, 32'd0, 32'h1111_0000, 32'd0, 5, 0);

      // Fetch x7 with coincident write of x7 (RF returns stale value)
      cyc("f7_wb", 0, 0, 7, 5, 1, 7, 32'hDEAD_BEEF, 32'h1111_0000, 32'd0, 5, 0);
      cyc("f7_byp", 1, 0, 0, 0, 0, 0, 32'd0, 32'hDEAD_BEEF, 32'h1111_0000, 7, 5);

      // Fetch x3, four stall cycles, writeback x3 in the second
      cyc("f3", 0, 0, 3, 7, 0, 0, 32'd0, 32'hDEAD_BEEF, 32'h1111_0000, 7, 5);
      cyc("st1", 1, 1, 0, 0, 0, 0, 32'd0, 32'h0000_0033, 32'hDEAD_BEEF, 3, 7);
      cyc("st2_wb", 1, 1, 0, 0, 1, 3, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 3, 7);
      cyc("st3", 1, 1, 0, 0, 0, 0, 32'd0, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 3, 7);
      cyc("st4", 1, 1, 0, 0, 0, 0, 32'd0, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 3, 7);

      // x0 on both sources while x0 is written every cycle
      cyc("x0_a", 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 3, 7);
      cyc("x0_b", 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, 0);
      cyc("x0_c", 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, 0);

      // Fetch x9 into HOLD, then reset mid-stall
      cyc("f9", 0, 0, 9, 9, 0, 0, 32'd0, 32'd0, 32'd0, 0, 0);
      cyc("f9_res", 1, 0, 0, 0, 0, 0, 32'd0, 32'h0000_0042, 32'h0000_0042, 9, 9);
      cyc("f9_hold", 1, 0, 0, 0, 0, 0, 32'd0, 32'h0000_0042, 32'h0000_0042, 9, 9);
      rst_n = 1'b0;
      #1;
      push_exp("rst_mid", 32'd0, 32'd0, 0, 0, 0, 0);
      pop_check();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc("post_rst_a", 1, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 0, 0);
      cyc("post_rst_b", 1, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 0, 0);

      // Both sources x12, writeback x12 in the consumption cycle
      cyc("f12", 0, 0, 12, 12, 0, 0, 32'd0, 32'd0, 32'd0, 0, 0);
      cyc("f12_fwd", 1, 0, 0, 0, 1, 12, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 12, 12);
      cyc("f12_hold", 1, 0, 0, 0, 0, 0, 32'd0, 32'h1234_5678, 32'h1234_5678, 12, 12);
      cyc("f12_last", 0, 0, 0, 0, 0, 0, 32'd0, 32'h1234_5678, 32'h1234_5678, 12, 12);

      total++;
      assert (sb.size() == 0) else begin
         bad++; $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_rf_operand_fetch

`default_nettype wire
